fp_mantissa_control: RTL and testbench
======================================

# fp_mantissa_control

Mantissa alignment and add/subtract stage of the IEEE-754 single-precision adder. Takes two 24-bit significands (hidden bit included), the exponent difference and its direction from the exponent-compare stage, and the operand signs plus the requested operation. It right-shifts the smaller-exponent significand, performs the effective add or subtract, and registers a 25-bit magnitude and result sign for the normalisation stage.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- diff_exp  input  8  unsigned exponent difference |exp_a − exp_b|.
- sign_exp  input  1  0: exp_a ≥ exp_b, so fraction_b is shifted; 1: exp_b > exp_a, so fraction_a is shifted.
- fraction_a  input  24  significand A, hidden bit in bit 23.
- fraction_b  input  24  significand B, hidden bit in bit 23.
- sign_a  input  1  sign of operand A (1 = negative).
- sign_b  input  1  sign of operand B.
- symbol  input  1  operation: 0 = A+B, 1 = A−B.
- out  output  25  registered result magnitude; bit 24 is the carry.
- sign_out  output  1  registered result sign.

## Operation
- Alignment: shifted operand = significand >> diff_exp (logical; zeros shifted in). Shifted-out bits are discarded; there are no guard, round or sticky bits. A diff_exp of 24 or more yields 0. The other operand passes unshifted.
- Let A', B' be the aligned values, zero-extended to 25 bits.
- Effective sign of B: sb = sign_b XOR symbol.
- If sign_a == sb: out = A' + B' (unsigned; the 25-bit result cannot overflow), and sign_out = sign_a.
- If sign_a != sb:
  - A' > B': out = A' − B', sign_out = sign_a.
  - B' > A': out = B' − A', sign_out = sb.
  - A' == B': out = 0, sign_out = 0 (+0).
- The result is not normalised. Leading-zero handling and exponent adjustment belong to the next stage.
- Purely datapath. No state beyond the output register.

## Timing
- Combinational computation from inputs. out and sign_out are registered on the rising edge of clk.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N and stay until edge N+1.
- Throughput is one operation per cycle. No handshake and no valid/ready; inputs may change every cycle.
- Reset: out = 0 and sign_out = 0 immediately on rst assertion, independent of clk. Registers hold reset values while rst is high. The first capture occurs at the first rising edge after rst deasserts.
- Reset asserted mid-stream discards the in-flight result. There is no recovery behaviour beyond that.

## Test plan
- Add, B shifted: diff_exp=5, sign_exp=0, fraction_a=1500, fraction_b=37500, sign_a=sign_b=symbol=0 -> after one edge, out=2671, sign_out=0.
- Add with carry into bit 24: diff_exp=5, sign_exp=0, fraction_a=16777211, fraction_b=1500, all signs 0, symbol=0 -> out=16777257 (bit 24 set), sign_out=0.
- Add, A shifted: diff_exp=5, sign_exp=1, fraction_a=1500, fraction_b=37500, all signs 0, symbol=0 -> out=37546, sign_out=0.
- Shift saturation: diff_exp=25, sign_exp=1, fraction_a=15000, fraction_b=36500, all signs 0, symbol=0 -> out=36500, sign_out=0.
- Subtract with B larger: diff_exp=5, sign_exp=1, fraction_a=15000, fraction_b=36500, sign_a=sign_b=0, symbol=1 -> out=36032, sign_out=1.
- Exact cancel and reset:
  - diff_exp=0, fraction_a=fraction_b=8388608, sign_a=0, sign_b=1, symbol=0 -> out=0, sign_out=0.
  - Then assert rst between edges -> out=0 and sign_out=0 without a clock edge.

Source files
------------

// File: rtl/fp_mantissa_control.sv
// Mantissa alignment and effective add/subtract stage of the single-precision adder.
// Aligns the smaller-exponent significand and produces an unnormalised 25-bit magnitude and sign.
module fp_mantissa_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  diff_exp,
   input  logic        sign_exp,
   input  logic [23:0] fraction_a,
   input  logic [23:0] fraction_b,
   input  logic        sign_a,
   input  logic        sign_b,
   input  logic        symbol,
   output logic [24:0] out,
   output logic        sign_out
);

   localparam int unsigned FRAC_W = 24;
   localparam int unsigned SUM_W  = FRAC_W + 1;

   logic [FRAC_W-1:0] shift_src;
   logic [FRAC_W-1:0] shifted;
   logic [SUM_W-1:0]  a_al;
   logic [SUM_W-1:0]  b_al;
   logic              sb_eff;
   logic [SUM_W-1:0]  out_d;
   logic [SUM_W-1:0]  out_q;
   logic              sign_out_d;
   logic              sign_out_q;

   // Right-shift the smaller-exponent significand; shifts of a full width or more clear it.
   always_comb begin
      shift_src = sign_exp ? fraction_a : fraction_b;
      shifted   = '0;
      if (diff_exp < 8'(FRAC_W)) begin
         shifted = shift_src >> diff_exp;
      end
      a_al = sign_exp ? {1'b0, shifted}    : {1'b0, fraction_a};
      b_al = sign_exp ? {1'b0, fraction_b} : {1'b0, shifted};
   end

   // Effective add or magnitude subtract; an exact cancellation yields +0.
   always_comb begin
      sb_eff     = sign_b ^ symbol;
      out_d      = '0;
      sign_out_d = 1'b0;
      if (sign_a == sb_eff) begin
         out_d      = a_al + b_al;
         sign_out_d = sign_a;
      end else if (a_al > b_al) begin
         out_d      = a_al - b_al;
         sign_out_d = sign_a;
      end else if (b_al > a_al) begin
         out_d      = b_al - a_al;
         sign_out_d = sb_eff;
      end
   end

   // Output register; cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q      <= '0;
         sign_out_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         sign_out_q <= sign_out_d;
      end
   end

   assign out      = out_q;
   assign sign_out = sign_out_q;

endmodule

// File: tb/tb_fp_mantissa_control.sv
// Directed bench for fp_mantissa_control with hand-computed expected values.
module tb_fp_mantissa_control;

   logic        clk;
   logic        rst;
   logic [7:0]  diff_exp;
   logic        sign_exp;
   logic [23:0] fraction_a;
   logic [23:0] fraction_b;
   logic        sign_a;
   logic        sign_b;
   logic        symbol;
   logic [24:0] out;
   logic        sign_out;

   int checks;
   int failures;

   fp_mantissa_control dut (
      .clk        (clk),
      .rst        (rst),
      .diff_exp   (diff_exp),
      .sign_exp   (sign_exp),
      .fraction_a (fraction_a),
      .fraction_b (fraction_b),
      .sign_a     (sign_a),
      .sign_b     (sign_b),
      .symbol     (symbol),
      .out        (out),
      .sign_out   (sign_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag, input logic [24:0] exp_out, input logic exp_sign);
      checks++;
      assert (out === exp_out) else begin
         failures++;
         $error("FAIL %s out: got %0d expected %0d", tag, out, exp_out);
      end
      checks++;
      assert (sign_out === exp_sign) else begin
         failures++;
         $error("FAIL %s sign_out: got %0b expected %0b", tag, sign_out, exp_sign);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic se, input logic [23:0] fa,
                        input logic [23:0] fb, input logic sa, input logic sbi, input logic sym);
      diff_exp   = d;
      sign_exp   = se;
      fraction_a = fa;
      fraction_b = fb;
      sign_a     = sa;
      sign_b     = sbi;
      symbol     = sym;
   endtask

   // Apply one vector, let one rising edge capture it, then check just after the edge.
   task automatic step(input string tag, input logic [7:0] d, input logic se,
                       input logic [23:0] fa, input logic [23:0] fb, input logic sa,
                       input logic sbi, input logic sym, input logic [24:0] exp_out,
                       input logic exp_sign);
      drive(d, se, fa, fb, sa, sbi, sym);
      @(posedge clk);
      #1;
      check_out(tag, exp_out, exp_sign);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      drive(8'd5, 1'b0, 24'd1500, 24'd37500, 1'b0, 1'b0, 1'b0);
      #2;
      check_out("reset_initial", 25'd0, 1'b0);

      // Held in reset across an edge with live inputs.
      @(posedge clk);
      #1;
      check_out("reset_hold", 25'd0, 1'b0);
      rst = 1'b0;

      step("add_b_shifted",   8'd5,  1'b0, 24'd1500,     24'd37500, 1'b0, 1'b0, 1'b0, 25'd2671,     1'b0);
      step("add_carry",       8'd5,  1'b0, 24'd16777211, 24'd1500,  1'b0, 1'b0, 1'b0, 25'd16777257, 1'b0);
      step("add_a_shifted",   8'd5,  1'b1, 24'd1500,     24'd37500, 1'b0, 1'b0, 1'b0, 25'd37546,    1'b0);
      step("shift_sat_25",    8'd25, 1'b1, 24'd15000,    24'd36500, 1'b0, 1'b0, 1'b0, 25'd36500,    1'b0);
      step("sub_b_larger",    8'd5,  1'b1, 24'd15000,    24'd36500, 1'b0, 1'b0, 1'b1, 25'd36032,    1'b1);
      step("sub_a_larger",    8'd5,  1'b0, 24'd37500,    24'd1500,  1'b0, 1'b0, 1'b1, 25'd37454,    1'b0);
      step("add_both_neg",    8'd0,  1'b0, 24'd1000,     24'd234,   1'b1, 1'b1, 1'b0, 25'd1234,     1'b1);
      step("sub_neg_b_eff",   8'd0,  1'b0, 24'd100,      24'd50,    1'b1, 1'b0, 1'b1, 25'd150,      1'b1);
      step("mixed_a_neg_big", 8'd1,  1'b0, 24'd1000,     24'd400,   1'b1, 1'b0, 1'b0, 25'd800,      1'b1);
      step("shift_24_zero",   8'd24, 1'b0, 24'd100,      24'd16777215, 1'b0, 1'b0, 1'b0, 25'd100,   1'b0);
      step("shift_23_one",    8'd23, 1'b0, 24'd100,      24'd16777215, 1'b0, 1'b0, 1'b0, 25'd101,   1'b0);
      step("shift_255_zero",  8'd255,1'b1, 24'd16777215, 24'd7,     1'b0, 1'b0, 1'b0, 25'd7,        1'b0);
      step("exact_cancel",    8'd0,  1'b0, 24'd8388608,  24'd8388608, 1'b0, 1'b1, 1'b0, 25'd0,      1'b0);
      step("cancel_neg_a",    8'd0,  1'b0, 24'd8388608,  24'd8388608, 1'b1, 1'b1, 1'b1, 25'd0,      1'b0);
      step("pre_reset",       8'd0,  1'b0, 24'd500,      24'd300,   1'b1, 1'b1, 1'b0, 25'd800,      1'b1);

      // Asynchronous reset between edges clears outputs without a clock edge.
      #2;
      rst = 1'b1;
      #1;
      check_out("async_reset", 25'd0, 1'b0);
      #3;
      rst = 1'b0;

      // First capture after reset release.
      step("post_reset",      8'd2,  1'b0, 24'd64,       24'd64,    1'b0, 1'b0, 1'b0, 25'd80,       1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
